aes_dec_round_ctrl: RTL and testbench

Iterative AES inverse-cipher sequencer. It time-multiplexes one inverse-round datapath over Nr+1 round-key applications instead of unrolling Nr rounds. It sits between the SPI front end, which supplies ciphertext and collects plaintext, and the expanded-key store, which it indexes one round key per cycle. It owns the 128-bit state register, the round counter and the valid/ready handshakes.

---
 rtl/aes_pkg.sv | 59 +++++
 rtl/aes_dec_round_ctrl_if.sv | 28 ++
 rtl/aes_inv_round.sv | 38 +++
 rtl/aes_dec_round_ctrl.sv | 116 +++++++++++
 tb/tb_aes_dec_round_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES inverse-cipher controller.
//   - BLOCK_W / RK_IDX_W : data block width and round-key index width
//   - ctrl_state_t       : controller sequencing states
//   - nr_from_nk         : number of rounds for a given key length in words
//   - xtime / gf_mul     : GF(2^8) arithmetic with the AES polynomial 0x11b
//   - inv_sbox           : AES inverse S-box computed arithmetically
package aes_pkg;

    localparam int BLOCK_W  = 128;
    localparam int RK_IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } ctrl_state_t;

    function automatic int nr_from_nk(input int nk);
        case (nk)
            6:       return 12;
            8:       return 14;
            default: return 10;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = xtime(sh);
        end
        return acc;
    endfunction

    // Inverse affine transform followed by the multiplicative inverse.
    // The inverse is a^254; zero maps to zero without a special case.
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] a;
        logic [7:0] pw;
        logic [7:0] res;
        a   = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        pw  = a;
        res = 8'h01;
        for (int i = 0; i < 7; i++) begin
            pw  = gf_mul(pw, pw);
            res = gf_mul(res, pw);
        end
        return res;
    endfunction

endpackage

// File: rtl/aes_dec_round_ctrl_if.sv
// Bus bundle between the inverse-cipher controller and its neighbours.
//   key_valid/rk_idx/rk_data       : expanded-key store lookup
//   in_valid/in_ready/in_data      : ciphertext from the SPI front end
//   out_valid/out_ready/out_data   : plaintext back to the SPI front end
// Modport slave is the controller side, master is the surrounding system.
interface aes_dec_round_ctrl_if;

    logic                          key_valid;
    logic [aes_pkg::RK_IDX_W-1:0]  rk_idx;
    logic [aes_pkg::BLOCK_W-1:0]   rk_data;
    logic                          in_valid;
    logic                          in_ready;
    logic [aes_pkg::BLOCK_W-1:0]   in_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [aes_pkg::BLOCK_W-1:0]   out_data;

    modport slave (
        input  key_valid, rk_data, in_valid, in_data, out_ready,
        output rk_idx, in_ready, out_valid, out_data
    );

    modport master (
        output key_valid, rk_data, in_valid, in_data, out_ready,
        input  rk_idx, in_ready, out_valid, out_data
    );

endinterface

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round:
//   InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns
// Ports: state_in (block), rk (round key), last (skip InvMixColumns),
//        state_out (result). Byte 0 sits at [127:120], column-major.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] state_in,
    input  logic [BLOCK_W-1:0] rk,
    input  logic               last,
    output logic [BLOCK_W-1:0] state_out
);

    logic [15:0][7:0] keyed;
    logic [15:0][7:0] mixed;

    // Byte gi is row gi%4, column gi/4; InvShiftRows rotates row r right by r,
    // so it takes its value from column (col - row) mod 4 of the input.
    for (genvar gi = 0; gi < 16; gi++) begin : g_byte
        localparam int ROW = gi % 4;
        localparam int COL = gi / 4;
        localparam int SRC = ROW + 4 * ((COL - ROW + 4) % 4);
        assign keyed[gi] = inv_sbox(state_in[BLOCK_W-1-8*SRC -: 8]) ^ rk[BLOCK_W-1-8*gi -: 8];
        assign state_out[BLOCK_W-1-8*gi -: 8] = last ? keyed[gi] : mixed[gi];
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_col
        assign mixed[4*gi+0] = gf_mul(8'h0e, keyed[4*gi]) ^ gf_mul(8'h0b, keyed[4*gi+1])
                             ^ gf_mul(8'h0d, keyed[4*gi+2]) ^ gf_mul(8'h09, keyed[4*gi+3]);
        assign mixed[4*gi+1] = gf_mul(8'h09, keyed[4*gi]) ^ gf_mul(8'h0e, keyed[4*gi+1])
                             ^ gf_mul(8'h0b, keyed[4*gi+2]) ^ gf_mul(8'h0d, keyed[4*gi+3]);
        assign mixed[4*gi+2] = gf_mul(8'h0d, keyed[4*gi]) ^ gf_mul(8'h09, keyed[4*gi+1])
                             ^ gf_mul(8'h0e, keyed[4*gi+2]) ^ gf_mul(8'h0b, keyed[4*gi+3]);
        assign mixed[4*gi+3] = gf_mul(8'h0b, keyed[4*gi]) ^ gf_mul(8'h0d, keyed[4*gi+1])
                             ^ gf_mul(8'h09, keyed[4*gi+2]) ^ gf_mul(8'h0e, keyed[4*gi+3]);
    end

endmodule

// File: rtl/aes_dec_round_ctrl.sv
// Iterative AES inverse-cipher sequencer. One inverse-round datapath is reused
// for Nr+1 round-key applications; the key store is indexed one key per cycle.
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous active-low reset
//   bus   : key store, ciphertext input and plaintext output handshakes
//   busy  : high while decrypting (ROUND or FINAL)
//   abort : one-cycle pulse when the key disappears mid-operation
module aes_dec_round_ctrl
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = nr_from_nk(Nk),
    parameter int Nb = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    aes_dec_round_ctrl_if.slave  bus,
    output logic                 busy,
    output logic                 abort
);

    localparam int STATE_W = 32 * Nb;
    localparam logic [RK_IDX_W-1:0] LAST_IDX = RK_IDX_W'(Nr);
    localparam logic [RK_IDX_W-1:0] CNT_INIT = RK_IDX_W'(Nr - 1);

    ctrl_state_t         fsm_reg;
    logic [RK_IDX_W-1:0] cnt_reg;
    logic [STATE_W-1:0]  blk_reg;
    logic                out_valid_reg;
    logic                abort_reg;

    logic [RK_IDX_W-1:0] rk_idx;
    logic                in_ready;
    logic [BLOCK_W-1:0]  round_out;

    aes_inv_round u_round (
        .state_in  (blk_reg),
        .rk        (bus.rk_data),
        .last      (fsm_reg == FINAL),
        .state_out (round_out)
    );

    // The key index follows the state: last key while waiting/draining,
    // the counter during the middle rounds, key 0 for the final round.
    always_comb begin
        rk_idx = LAST_IDX;
        case (fsm_reg)
            ROUND:   rk_idx = cnt_reg;
            FINAL:   rk_idx = '0;
            default: ;
        endcase
    end

    assign in_ready      = (fsm_reg == IDLE) && bus.key_valid;
    assign bus.in_ready  = in_ready;
    assign bus.rk_idx    = rk_idx;
    assign bus.out_valid = out_valid_reg;
    // Intermediate round state never leaks onto the output bus.
    assign bus.out_data  = out_valid_reg ? blk_reg : '0;
    assign busy          = (fsm_reg == ROUND) || (fsm_reg == FINAL);
    assign abort         = abort_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_reg       <= IDLE;
            cnt_reg       <= CNT_INIT;
            blk_reg       <= '0;
            out_valid_reg <= 1'b0;
            abort_reg     <= 1'b0;
        end else begin
            abort_reg <= 1'b0;
            case (fsm_reg)
                IDLE: begin
                    if (bus.in_valid && in_ready) begin
                        blk_reg <= bus.in_data ^ bus.rk_data;
                        cnt_reg <= CNT_INIT;
                        fsm_reg <= ROUND;
                    end
                end
                ROUND: begin
                    if (!bus.key_valid) begin
                        fsm_reg   <= IDLE;
                        abort_reg <= 1'b1;
                    end else begin
                        blk_reg <= round_out;
                        if (cnt_reg == RK_IDX_W'(1)) begin
                            fsm_reg <= FINAL;
                        end else begin
                            cnt_reg <= cnt_reg - RK_IDX_W'(1);
                        end
                    end
                end
                FINAL: begin
                    if (!bus.key_valid) begin
                        fsm_reg   <= IDLE;
                        abort_reg <= 1'b1;
                    end else begin
                        blk_reg       <= round_out;
                        out_valid_reg <= 1'b1;
                        fsm_reg       <= DONE;
                    end
                end
                DONE: begin
                    // A dropped key no longer matters: the plaintext is complete.
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        fsm_reg       <= IDLE;
                    end
                end
                default: fsm_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// Testbench for aes_dec_round_ctrl. Acts as SPI front end and key store.
// Reference: forward AES-128 (key expansion + cipher) built from its own
// S-box table; random plaintexts are encrypted here and the DUT must return them.
module tb_aes_dec_round_ctrl;

    localparam int NR = 10;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic abort;

    always #5 clk = ~clk;

    aes_dec_round_ctrl_if bus ();

    aes_dec_round_ctrl #(.Nk(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .busy  (busy),
        .abort (abort)
    );

    logic [127:0] rk [0:15];
    logic [7:0]   sbox [0:255];

    assign bus.rk_data = rk[bus.rk_idx];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
        logic [15:0] d;
        d = {v, v};
        return d[15-k -: 8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++) begin
            if (r <= NR) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else         rk[r] = '0;
        end
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ rk[0][127-8*k -: 8];
        for (int rnd = 1; rnd <= NR; rnd++) begin
            for (int k = 0; k < 16; k++) s[k] = sbox[s[k]];
            for (int row = 0; row < 4; row++)
                for (int col = 0; col < 4; col++)
                    t[row + 4*col] = s[row + 4*((col + row) % 4)];
            s = t;
            if (rnd < NR) begin
                for (int col = 0; col < 4; col++) begin
                    a0 = s[4*col]; a1 = s[4*col+1]; a2 = s[4*col+2]; a3 = s[4*col+3];
                    s[4*col]   = gm(8'h02, a0) ^ gm(8'h03, a1) ^ a2 ^ a3;
                    s[4*col+1] = a0 ^ gm(8'h02, a1) ^ gm(8'h03, a2) ^ a3;
                    s[4*col+2] = a0 ^ a1 ^ gm(8'h02, a2) ^ gm(8'h03, a3);
                    s[4*col+3] = gm(8'h03, a0) ^ a1 ^ a2 ^ gm(8'h02, a3);
                end
            end
            for (int k = 0; k < 16; k++) s[k] = s[k] ^ rk[rnd][127-8*k -: 8];
        end
        for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Offer a block and return just after the accept edge.
    task automatic accept(input logic [127:0] ct);
        int n;
        n = 0;
        bus.in_data  = ct;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("accept_in_ready", 128'(bus.in_ready), 128'd1);
        chk("idle_rk_idx", 128'(bus.rk_idx), 128'(NR));
        tick();
        bus.in_valid = 1'b0;
    endtask

    // From the accept edge: key index counts Nr-1..0, then plaintext appears at E+Nr.
    task automatic finish_block(input logic [127:0] exp_pt);
        for (int k = 0; k < NR; k++) begin
            chk("rk_idx_seq", 128'(bus.rk_idx), 128'(NR - 1 - k));
            chk("busy_in_flight", 128'(busy), 128'd1);
            chk("no_early_out_valid", 128'(bus.out_valid), 128'd0);
            chk("in_ready_in_flight", 128'(bus.in_ready), 128'd0);
            chk("no_abort", 128'(abort), 128'd0);
            tick();
        end
        chk("latency_out_valid", 128'(bus.out_valid), 128'd1);
        chk("plaintext", bus.out_data, exp_pt);
        chk("busy_done", 128'(busy), 128'd0);
        chk("in_ready_done", 128'(bus.in_ready), 128'd0);
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        tick();
        chk("drained_out_valid", 128'(bus.out_valid), 128'd0);
        chk("idle_in_ready", 128'(bus.in_ready), 128'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] pt1, pt2, ct1, ct2, pt, ct;
        int gap;
        bit acc2, got1;

        rst           = 1'b0;
        bus.key_valid = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        build_sbox();
        expand_key(FIPS_KEY);
        if (encrypt(FIPS_PT) !== FIPS_CT) begin
            $display("FAIL model_sanity: observed %h expected %h", encrypt(FIPS_PT), FIPS_CT);
            $fatal(1, "reference model broken");
        end

        // Reset state
        tick();
        tick();
        chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("rst_out_data", bus.out_data, 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_abort", 128'(abort), 128'd0);
        chk("rst_rk_idx", 128'(bus.rk_idx), 128'(NR));
        chk("rst_in_ready_nokey", 128'(bus.in_ready), 128'd0);
        rst = 1'b1;
        bus.key_valid = 1'b1;
        tick();

        // 1. FIPS-197 C.1 vector
        bus.out_ready = 1'b1;
        accept(FIPS_CT);
        finish_block(FIPS_PT);
        drain();
        $display("txn fips: ct=%h pt=%h", FIPS_CT, FIPS_PT);

        // 2. Backpressure; a new offer during DONE must be ignored
        bus.out_ready = 1'b0;
        accept(FIPS_CT);
        finish_block(FIPS_PT);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = rand128();
            chk("bp_out_valid", 128'(bus.out_valid), 128'd1);
            chk("bp_out_data", bus.out_data, FIPS_PT);
            chk("bp_in_ready", 128'(bus.in_ready), 128'd0);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("bp_hold_before_ready", 128'(bus.out_valid), 128'd1);
        tick();
        chk("bp_complete", 128'(bus.out_valid), 128'd0);
        $display("txn backpressure: pt=%h", FIPS_PT);

        // 3. Back-to-back with in_valid held high
        pt1 = rand128();
        pt2 = rand128();
        ct1 = encrypt(pt1);
        ct2 = encrypt(pt2);
        bus.out_ready = 1'b1;
        accept(ct1);
        bus.in_valid = 1'b1;
        bus.in_data  = ct2;
        gap  = 0;
        acc2 = 1'b0;
        got1 = 1'b0;
        for (int c = 0; c < 40 && !acc2; c++) begin
            if (bus.out_valid && !got1) begin
                chk("b2b_first_pt", bus.out_data, pt1);
                got1 = 1'b1;
            end
            if (bus.in_ready) begin
                acc2 = 1'b1;
                gap  = c + 1;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        chk("b2b_first_seen", 128'(got1), 128'd1);
        chk("b2b_accept_gap", 128'(gap), 128'(NR + 2));
        finish_block(pt2);
        drain();
        $display("txn back_to_back: pt1=%h pt2=%h gap=%0d", pt1, pt2, gap);

        // 4. Key loss in ROUND at counter 5
        expand_key(rand128());
        pt = rand128();
        ct = encrypt(pt);
        accept(ct);
        repeat (4) tick();
        chk("kl_rk_idx5", 128'(bus.rk_idx), 128'd5);
        bus.key_valid = 1'b0;
        tick();
        chk("kl_abort_pulse", 128'(abort), 128'd1);
        chk("kl_busy", 128'(busy), 128'd0);
        chk("kl_out_valid", 128'(bus.out_valid), 128'd0);
        chk("kl_in_ready", 128'(bus.in_ready), 128'd0);
        chk("kl_rk_idx_idle", 128'(bus.rk_idx), 128'(NR));
        bus.in_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("kl_abort_once", 128'(abort), 128'd0);
            chk("kl_no_out_valid", 128'(bus.out_valid), 128'd0);
            chk("kl_no_in_ready", 128'(bus.in_ready), 128'd0);
            chk("kl_idle", 128'(busy), 128'd0);
        end
        bus.in_valid  = 1'b0;
        bus.key_valid = 1'b1;
        #1;
        chk("kl_key_back_ready", 128'(bus.in_ready), 128'd1);
        tick();
        $display("txn key_loss: aborted at rk_idx 5");

        // 5. Asynchronous reset mid-operation
        accept(ct);
        repeat (6) tick();
        chk("rs_rk_idx3", 128'(bus.rk_idx), 128'd3);
        rst = 1'b0;
        #1;
        chk("rs_busy", 128'(busy), 128'd0);
        chk("rs_out_valid", 128'(bus.out_valid), 128'd0);
        chk("rs_abort", 128'(abort), 128'd0);
        chk("rs_rk_idx", 128'(bus.rk_idx), 128'(NR));
        chk("rs_out_data", bus.out_data, 128'd0);
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("rs_no_out_valid", 128'(bus.out_valid), 128'd0);
            chk("rs_not_busy", 128'(busy), 128'd0);
        end
        accept(ct);
        finish_block(pt);
        drain();
        $display("txn reset_recovery: pt=%h", pt);

        // 6. Idle without key
        bus.key_valid = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = rand128();
        #1;
        for (int i = 0; i < 20; i++) begin
            chk("nk_in_ready", 128'(bus.in_ready), 128'd0);
            chk("nk_busy", 128'(busy), 128'd0);
            chk("nk_out_valid", 128'(bus.out_valid), 128'd0);
            chk("nk_rk_idx", 128'(bus.rk_idx), 128'(NR));
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.key_valid = 1'b1;
        tick();
        $display("txn idle_no_key: 20 cycles held");

        // Random keys and plaintexts with random drain delay
        for (int n = 0; n < 6; n++) begin
            expand_key(rand128());
            pt = rand128();
            ct = encrypt(pt);
            bus.out_ready = 1'b0;
            accept(ct);
            finish_block(pt);
            repeat ($urandom_range(0, 3)) begin
                tick();
                chk("rnd_hold_valid", 128'(bus.out_valid), 128'd1);
                chk("rnd_hold_data", bus.out_data, pt);
            end
            drain();
            $display("txn random %0d: ct=%h pt=%h", n, ct, pt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
